// File: rtl/RCA_8bit.sv
// 8-bit ripple-carry adder built from a chain of full-adder bit slices.
module RCA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       carry
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign carry = c[8];

endmodule

// File: rtl/rca_accum.sv
// Accumulates a job of 'count' unsigned bytes into a (CNT_W+8)-bit sum.
// The low byte uses RCA_8bit, and its carry-out increments the upper bits.
module rca_accum #(
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   count,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W+7:0]   result
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W+7:0] acc;
    logic [CNT_W-1:0] remaining;

    logic [7:0]       lo_sum;
    logic             lo_carry;
    logic [CNT_W-1:0] hi_sum;

    RCA_8bit u_rca (
        .a     (acc[7:0]),
        .b     (in_data),
        .cin   (1'b0),
        .sum   (lo_sum),
        .carry (lo_carry)
    );

    // The maximum job sum fits in CNT_W+8 bits, so this increment cannot wrap.
    assign hi_sum = acc[CNT_W+7:8] + CNT_W'(lo_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        if (count == '0) begin
                            state <= DONE;
                        end else begin
                            remaining <= count;
                            state     <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    // in_ready is high throughout ACCUM, so in_valid alone marks a transfer.
                    if (in_valid) begin
                        acc       <= {hi_sum, lo_sum};
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == ACCUM);
    assign busy     = (state == ACCUM) || (state == DONE);
    assign done     = (state == DONE);
    assign result   = acc;

endmodule

// File: tb/tb_rca_accum.sv
// Randomized and directed bench for rca_accum against a job-level sum model.
module tb_rca_accum;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [CNT_W+7:0] result;

    int n_checks = 0;
    int n_errors = 0;
    int xfers    = 0;

    // Model: phase 0 = waiting for start, 1 = collecting operands, 2 = reporting.
    int m_phase = 0;
    int m_left  = 0;
    int m_sum   = 0;

    rca_accum #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .count    (count),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_sum   = 0;
        end else begin
            if (m_phase == 0) begin
                if (start) begin
                    m_sum = 0;
                    if (count == 0) begin
                        m_phase = 2;
                    end else begin
                        m_left  = int'(count);
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    m_sum  = m_sum + int'(in_data);
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", longint'(in_ready), longint'(m_phase == 1));
        check("busy",     longint'(busy),     longint'(m_phase != 0));
        check("done",     longint'(done),     longint'(m_phase == 2));
        check("result",   longint'(result),   longint'(m_sum));
        if (in_valid && in_ready) xfers++;
    end

    task automatic start_job(input int cnt);
        start = 1'b1;
        count = CNT_W'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap, input bit noise);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy still 1, expected 0 within 40 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int x0;
        rst_n    = 1'b0;
        start    = 1'b0;
        count    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_busy",     longint'(busy),     0);
        check("rst_done",     longint'(done),     0);
        check("rst_result",   longint'(result),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0x0F + 0x05, back-to-back.
        start_job(2);
        send(8'h0F, 0, 1'b0);
        send(8'h05, 0, 1'b0);
        @(negedge clk);
        check("j1_done_at_start_plus_3", longint'(done), 1);
        check("j1_result", longint'(result), 20);
        wait_idle();
        check("j1_result_held", longint'(result), 20);

        // 0xF0, two idle cycles, then 0x0F.
        start_job(2);
        send(8'hF0, 0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            check("j2_ready_in_gap", longint'(in_ready), 1);
            check("j2_result_in_gap", longint'(result), 240);
            @(posedge clk);
            #1;
        end
        send(8'h0F, 0, 1'b0);
        @(negedge clk);
        check("j2_result", longint'(result), 255);
        check("j2_upper", longint'(result[CNT_W+7:8]), 0);
        wait_idle();

        // 0xFF + 0xFF carries into the upper bits.
        start_job(2);
        send(8'hFF, 0, 1'b0);
        send(8'hFF, 0, 1'b0);
        @(negedge clk);
        check("j3_result", longint'(result), 510);
        wait_idle();

        // Fifteen 0xFF operands.
        x0 = xfers;
        start_job(15);
        for (int i = 0; i < 15; i++) send(8'hFF, 0, 1'b0);
        @(negedge clk);
        check("j4_done", longint'(done), 1);
        check("j4_ready_in_done", longint'(in_ready), 0);
        check("j4_result", longint'(result), 3825);
        check("j4_xfers", longint'(xfers - x0), 15);
        wait_idle();

        // count=0 finishes immediately with result 0.
        x0 = xfers;
        start_job(0);
        @(negedge clk);
        check("j5_done", longint'(done), 1);
        check("j5_ready", longint'(in_ready), 0);
        check("j5_result", longint'(result), 0);
        wait_idle();
        check("j5_no_xfers", longint'(xfers - x0), 0);

        // A start pulse in the middle of a job must not restart it.
        start_job(2);
        send(8'h03, 0, 1'b0);
        start = 1'b1;
        count = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(8'h04, 0, 1'b0);
        @(negedge clk);
        check("j6_done", longint'(done), 1);
        check("j6_result", longint'(result), 7);
        wait_idle();

        // Reset after the second of three transfers abandons the job.
        start_job(3);
        send(8'h11, 0, 1'b0);
        send(8'h22, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("j7_rst_result", longint'(result), 0);
        check("j7_rst_busy", longint'(busy), 0);
        start = 1'b1;
        count = 4'd1;
        repeat (3) begin
            @(negedge clk);
            check("j7_no_done", longint'(done), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("j7_first_edge_start", longint'(busy), 1);
        send(8'h07, 0, 1'b0);
        @(negedge clk);
        check("j7_result", longint'(result), 7);
        wait_idle();

        // Random jobs with random gaps and stray start pulses during collection.
        for (int j = 0; j < 40; j++) begin
            cnt = int'($urandom_range(0, 15));
            start_job(cnt);
            for (int i = 0; i < cnt; i++) begin
                send(8'($urandom), int'($urandom_range(0, 3)), 1'b1);
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rca_accum.md
RCA_ACCUM -- requirements
Module: rca_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of operand-count input (max operands 2^CNT_W-1).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin accumulation job, sampled only in IDLE.
REQ-005 SHALL have port count  input  CNT_W  number of 8-bit operands in the job, sampled with start.
REQ-006 SHALL have port in_valid  input  1  operand present on in_data.
REQ-007 SHALL have port in_data  input  8  unsigned operand.
REQ-008 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-009 SHALL have port busy  output  1  high in ACCUM and DONE states.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  CNT_W+8  unsigned sum of the job's operands.

Function
REQ-012 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-013 IDLE: start=1 and count!=0 -> clear accumulator to 0, load remaining=count, go ACCUM.
REQ-014 IDLE: start=1 and count=0 -> clear accumulator to 0, go DONE directly (result 0).
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 in_ready SHALL be 1 exactly when state is ACCUM (combinational from state, not from in_valid).
REQ-017 Transfer occurs when in_valid and in_ready are both 1 on a rising edge; no other cycle modifies the accumulator.
REQ-018 On transfer: low byte <= 8-bit sum of low byte and in_data (carry-in 0); upper CNT_W bits <= upper bits + carry-out; remaining <= remaining-1.
REQ-019 Transfer with remaining=1 SHALL move state to DONE; otherwise stay in ACCUM.
REQ-020 in_valid gaps in ACCUM SHALL stall without changing accumulator or remaining.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 result SHALL equal the accumulator at all times; it holds its final value in IDLE until the next accepted start.
REQ-023 Latency: done asserts the cycle after the last transfer; a start->done job of N operands with no gaps takes N+1 cycles after the start edge.
REQ-024 Width rule: (2^CNT_W-1)*255 fits in CNT_W+8 bits; no overflow path exists or is flagged.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, accumulator 0, remaining 0.
REQ-026 Reset outputs: in_ready=0, busy=0, done=0, result=0.
REQ-027 Reset asserted mid-job SHALL abandon the job; no done pulse after release; next job requires a fresh start.
REQ-028 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 State encoding SHALL be localparams in the module; no shared package needed for this block.
REQ-030 Low-byte addition SHALL instantiate the existing RCA_8bit (ports a, b, cin, sum, carry) with cin tied 0; no other sub-modules.
REQ-031 Upper-bit increment SHALL be a plain CNT_W-bit adder of the RCA_8bit carry output.

Verification
REQ-032 count=2, operands 0x0F, 0x05 back-to-back -> result=20, done pulse 3 cycles after start edge.
REQ-033 count=2, operands 0xF0, 0x0F with 2-cycle in_valid gap between -> result=255, in_ready held high through gap, upper bits 0.
REQ-034 count=2, operands 0xFF, 0xFF -> result=510 (0x1FE), carry propagated into upper bits.
REQ-035 count=15, all operands 0xFF -> result=3825 (0xEF1), exactly 15 transfers, in_ready drops in DONE.
REQ-036 count=0 start -> done pulse next cycle, result=0, in_ready never asserted; start pulsed during ACCUM of another job ignored.
REQ-037 count=3, reset asserted after 2nd transfer -> result=0 immediately, no done; new job count=1 operand 0x07 -> result=7.
